// File: rtl/array_ops_pkg.sv
// Shared helpers for packing and unpacking column-major element vectors.
// Used by the serial packer and by the downstream 1D-to-2D converter.
package array_ops_pkg;

    // Width of a counter that must hold 0..cols, never narrower than one bit.
    function automatic int cnt_width(input int cols);
        return (cols < 1) ? 1 : $clog2(cols + 1);
    endfunction

    // LSB position of column i inside a packed vector.
    function automatic int col_lsb(input int i, input int bit_width);
        return i * bit_width;
    endfunction

endpackage

// File: rtl/serial_to_packed_array.sv
// Packs a valid/ready stream of BIT_WIDTH-bit elements into COLS-column vectors,
// column 0 in the LSBs, with optional early termination via in_last.
module serial_to_packed_array
    import array_ops_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int COLS      = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [BIT_WIDTH-1:0]            in_data,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    output logic [COLS*BIT_WIDTH-1:0]       out_data,
    output logic [cnt_width(COLS)-1:0]      out_cols,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int CW = cnt_width(COLS);
    localparam int DW = COLS * BIT_WIDTH;

    logic [DW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_out_data;
    logic [CW-1:0]   r_out_cols;
    logic            r_out_valid;

    logic            w_accept;
    logic            w_complete;
    logic [COLS-1:0] w_col_en;
    logic [DW-1:0]   w_merged;

    // Stalls the whole input side, not just completing beats, while a vector waits.
    assign in_ready   = ~r_out_valid | out_ready;
    assign w_accept   = in_valid & in_ready;
    assign w_complete = w_accept & ((r_cnt == CW'(COLS - 1)) | in_last);

    // Accumulator with the current column replaced by the incoming element.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            localparam int LSB = col_lsb(gi, BIT_WIDTH);
            assign w_col_en[gi] = w_accept & (r_cnt == CW'(gi));
            assign w_merged[LSB +: BIT_WIDTH] =
                w_col_en[gi] ? in_data : r_acc[LSB +: BIT_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_cols  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_complete) begin
            // Clearing acc here is what zero-fills columns of short vectors.
            r_out_data  <= w_merged;
            r_out_cols  <= r_cnt + CW'(1);
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_acc <= w_merged;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_cols  = r_out_cols;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_serial_to_packed_array.sv
// Directed self-checking bench for serial_to_packed_array (4x4 instance plus a COLS=1, 8-bit instance).
module tb_serial_to_packed_array;

    logic        clk;
    logic        rst_n;

    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_data;
    logic [2:0]  out_cols;
    logic        out_valid;
    logic        out_ready;

    logic [7:0]  b_in_data;
    logic        b_in_valid;
    logic        b_in_last;
    logic        b_in_ready;
    logic [7:0]  b_out_data;
    logic [0:0]  b_out_cols;
    logic        b_out_valid;
    logic        b_out_ready;

    int checks;
    int failures;

    serial_to_packed_array #(.BIT_WIDTH(4), .COLS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_cols  (out_cols),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    serial_to_packed_array #(.BIT_WIDTH(8), .COLS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_last   (b_in_last),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_cols  (b_out_cols),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat and advance to just after the sampling edge.
    task automatic put(input logic [3:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = 4'h0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_last = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_cols !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b data=%h cols=%0d, want valid=0 data=0000 cols=0",
                     out_valid, out_data, out_cols);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("test_reset: out_valid=%b out_data=%h in_ready=%b", out_valid, out_data, in_ready);
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        put(4'h1, 1'b0);
        put(4'h2, 1'b0);
        put(4'h3, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_early_valid: got out_valid=%b after 3 beats, want 0", out_valid);
        end
        put(4'h4, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h4321 || out_cols !== 3'd4) begin
            failures++;
            $display("FAIL stream_vector: got valid=%b data=%h cols=%0d, want valid=1 data=4321 cols=4",
                     out_valid, out_data, out_cols);
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_consume: got out_valid=%b after consume, want 0", out_valid);
        end
        $display("test_stream: vector=%h cols=%0d", out_data, out_cols);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            in_last  = 1'b0;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_in_ready: beat %0d got in_ready=%b, want 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            if (i == 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 16'h4321 || out_cols !== 3'd4) begin
                    failures++;
                    $display("FAIL b2b_vec0: got valid=%b data=%h cols=%0d, want valid=1 data=4321 cols=4",
                             out_valid, out_data, out_cols);
                end
            end else if (i == 8) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 16'h8765 || out_cols !== 3'd4) begin
                    failures++;
                    $display("FAIL b2b_vec1: got valid=%b data=%h cols=%0d, want valid=1 data=8765 cols=4",
                             out_valid, out_data, out_cols);
                end
            end else if (i > 4) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_mid_valid: beat %0d got out_valid=%b, want 0", i, out_valid);
                end
            end
        end
        idle_cycle();
        $display("test_back_to_back: last vector=%h", out_data);
    endtask

    task automatic test_early_last();
        out_ready = 1'b1;
        put(4'hA, 1'b0);
        put(4'hB, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00BA || out_cols !== 3'd2) begin
            failures++;
            $display("FAIL early_last: got valid=%b data=%h cols=%0d, want valid=1 data=00ba cols=2",
                     out_valid, out_data, out_cols);
        end
        put(4'h1, 1'b0);
        put(4'h2, 1'b0);
        put(4'h3, 1'b0);
        put(4'h4, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h4321 || out_cols !== 3'd4) begin
            failures++;
            $display("FAIL early_last_next: got valid=%b data=%h cols=%0d, want valid=1 data=4321 cols=4",
                     out_valid, out_data, out_cols);
        end
        idle_cycle();
        $display("test_early_last: short=00ba next=%h", out_data);
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        put(4'h1, 1'b0);
        put(4'h2, 1'b0);
        put(4'h3, 1'b0);
        put(4'h4, 1'b0);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 4'h5;
            in_last  = 1'b0;
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h4321) begin
                failures++;
                $display("FAIL stall_hold: cycle %0d got in_ready=%b valid=%b data=%h, want 0/1/4321",
                         c, in_ready, out_valid, out_data);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: got in_ready=%b, want 1 same cycle", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_drain: got out_valid=%b, want 0", out_valid);
        end
        put(4'h6, 1'b0);
        put(4'h7, 1'b0);
        put(4'h8, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h8765 || out_cols !== 3'd4) begin
            failures++;
            $display("FAIL stall_next: got valid=%b data=%h cols=%0d, want valid=1 data=8765 cols=4",
                     out_valid, out_data, out_cols);
        end
        idle_cycle();
        $display("test_stall: held=4321 next=%h", out_data);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        put(4'h9, 1'b0);
        put(4'hA, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_cols !== 3'd0) begin
            failures++;
            $display("FAIL async_reset: got valid=%b data=%h cols=%0d, want all 0",
                     out_valid, out_data, out_cols);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        put(4'h5, 1'b0);
        put(4'h6, 1'b0);
        put(4'h7, 1'b0);
        put(4'h8, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h8765 || out_cols !== 3'd4) begin
            failures++;
            $display("FAIL reset_discard: got valid=%b data=%h cols=%0d, want valid=1 data=8765 cols=4",
                     out_valid, out_data, out_cols);
        end
        idle_cycle();
        $display("test_async_reset: after reset vector=%h", out_data);
    endtask

    task automatic test_single_col();
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 8'hA5;
        @(posedge clk);
        #1;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'hA5 || b_out_cols !== 1'b1) begin
            failures++;
            $display("FAIL single_col_0: got valid=%b data=%h cols=%0d, want valid=1 data=a5 cols=1",
                     b_out_valid, b_out_data, b_out_cols);
        end
        b_in_data = 8'h3C;
        @(posedge clk);
        #1;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'h3C || b_out_cols !== 1'b1) begin
            failures++;
            $display("FAIL single_col_1: got valid=%b data=%h cols=%0d, want valid=1 data=3c cols=1",
                     b_out_valid, b_out_data, b_out_cols);
        end
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("test_single_col: a5 then %h", b_out_data);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_back_to_back();
        test_early_last();
        test_stall();
        test_async_reset();
        test_single_col();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
